// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment scan path:
// widths, enable constants, digit rotation order and blanking rules.
package display_pkg;

    localparam int N_DIGITOS    = 4;
    localparam int ANCHO_NIBBLE = 4;
    localparam int ANCHO_IDX    = 2;
    localparam int ANCHO_DATO   = N_DIGITOS * ANCHO_NIBBLE;

    localparam logic [N_DIGITOS-1:0] HAB_APAGADO = 4'b1111;

    typedef logic [ANCHO_NIBBLE-1:0] nibble_t;
    typedef logic [ANCHO_IDX-1:0]    idx_t;

    typedef enum logic [ANCHO_IDX-1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } estado_t;

    // A display value travels with its own blanking flag so both commit together.
    typedef struct packed {
        logic [ANCHO_DATO-1:0] valor;
        logic                  ceros_izq;
    } valor_t;

    function automatic estado_t siguiente_digito(input estado_t e);
        case (e)
            D0:      return D1;
            D1:      return D2;
            D2:      return D3;
            default: return D0;
        endcase
    endfunction

    function automatic nibble_t nibble_de(input logic [ANCHO_DATO-1:0] v, input idx_t d);
        return v[{d, 2'b00} +: ANCHO_NIBBLE];
    endfunction

    function automatic logic [N_DIGITOS-1:0] habilita_de(input idx_t d);
        return ~(4'b0001 << d);
    endfunction

    // Leading-zero rule: digit d goes dark when it and every digit to its left are
    // zero; digit 0 is always lit so a zero value still shows "0".
    function automatic logic digito_en_blanco(input valor_t v, input idx_t d);
        logic ceros_arriba;
        ceros_arriba = 1'b1;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (k >= int'(d) && v.valor[k*ANCHO_NIBBLE +: ANCHO_NIBBLE] != '0) begin
                ceros_arriba = 1'b0;
            end
        end
        return v.ceros_izq && (d != '0) && ceros_arriba;
    endfunction

endpackage

// File: rtl/divisor_barrido.sv
// Slot timer: counts 0..DIV-1 continuously and flags the last cycle of each slot.
module divisor_barrido #(
    parameter  int DIV       = 50000,
    localparam int ANCHO_CNT = $clog2(DIV)
) (
    input  logic                 reloj,
    input  logic                 reset_n,
    output logic [ANCHO_CNT-1:0] cnt,
    output logic                 fin_slot
);

    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(DIV - 1);

    assign fin_slot = (cnt == CNT_MAX);

    // NOTE: state registers use non-blocking assignments with an asynchronous
    // active-low reset so every flop settles together and reset acts mid-cycle.
    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (fin_slot) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_display.sv
// Scan controller for a 4-digit multiplexed 7-segment display: digit rotation,
// guard time, leading-zero blanking and frame-aligned load/commit of the value.
module controlador_display
    import display_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int GUARD = 4
) (
    input  logic                    reloj,
    input  logic                    reset_n,
    input  logic                    cargar,
    input  logic [ANCHO_DATO-1:0]   dato,
    input  logic                    ceros_izq,
    output logic [ANCHO_NIBBLE-1:0] Entrada,
    output logic [N_DIGITOS-1:0]    habilita,
    output logic [ANCHO_IDX-1:0]    digito,
    output logic                    ocupado,
    output logic                    fin_cuadro
);

    localparam int ANCHO_CNT = $clog2(DIV);

    logic [ANCHO_CNT-1:0] w_cnt;
    logic [ANCHO_CNT-1:0] w_cnt_sig;
    logic                 w_fin_slot;
    logic                 w_frontera;
    logic                 w_en_guarda;
    estado_t              w_dig_sig;
    valor_t               w_vis_sig;
    valor_t               w_carga;
    logic [N_DIGITOS-1:0] w_hab_sig;

    estado_t r_dig;
    valor_t  r_vis;
    valor_t  r_pend;

    divisor_barrido #(
        .DIV (DIV)
    ) u_divisor (
        .reloj    (reloj),
        .reset_n  (reset_n),
        .cnt      (w_cnt),
        .fin_slot (w_fin_slot)
    );

    // Value the slot counter will hold after this edge; outputs are registered
    // from next-state so Entrada/digito/habilita move on the same edge as cnt.
    assign w_cnt_sig = w_fin_slot ? '0 : w_cnt + 1'b1;

    generate
        if (GUARD == 0) begin : g_sin_guarda
            assign w_en_guarda = 1'b0;
        end else begin : g_guarda
            localparam logic [ANCHO_CNT-1:0] GUARD_C = ANCHO_CNT'(GUARD);
            assign w_en_guarda = (w_cnt_sig < GUARD_C);
        end
    endgenerate

    assign w_frontera = w_fin_slot && (r_dig == D3);
    assign w_dig_sig  = w_fin_slot ? siguiente_digito(r_dig) : r_dig;
    assign w_carga    = '{valor: dato, ceros_izq: ceros_izq};

    // Commit reads the pre-edge pending value, so a load landing on the
    // boundary edge waits a full frame instead of tearing this one.
    assign w_vis_sig  = (w_frontera && ocupado) ? r_pend : r_vis;

    assign w_hab_sig  = (w_en_guarda || digito_en_blanco(w_vis_sig, w_dig_sig))
                        ? HAB_APAGADO : habilita_de(w_dig_sig);

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            r_dig      <= D0;
            r_vis      <= '0;
            r_pend     <= '0;
            ocupado    <= 1'b0;
            Entrada    <= '0;
            habilita   <= HAB_APAGADO;
            digito     <= '0;
            fin_cuadro <= 1'b0;
        end else begin
            r_dig      <= w_dig_sig;
            r_vis      <= w_vis_sig;
            if (cargar) begin
                r_pend <= w_carga;
            end
            ocupado    <= cargar || (ocupado && !w_frontera);
            Entrada    <= nibble_de(w_vis_sig.valor, w_dig_sig);
            habilita   <= w_hab_sig;
            digito     <= w_dig_sig;
            fin_cuadro <= w_frontera;
        end
    end

endmodule

// File: tb/tb_controlador_display.sv
// Self-checking bench for controlador_display with a frame-arithmetic reference model.
module tb_controlador_display;

    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int CUADRO = 4 * DIV;

    logic        reloj     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cargar    = 1'b0;
    logic [15:0] dato      = 16'h0;
    logic        ceros_izq = 1'b0;
    logic [3:0]  Entrada;
    logic [3:0]  habilita;
    logic [1:0]  digito;
    logic        ocupado;
    logic        fin_cuadro;

    int errores = 0;
    int checks  = 0;

    // Reference model: edges since reset, visible/pending values, load flag.
    int          m_k;
    logic [15:0] m_vis, m_pend;
    logic        m_cz, m_pcz, m_ocup, m_fin;

    logic [11:0] w_obs;
    assign w_obs = {Entrada, habilita, digito, ocupado, fin_cuadro};

    controlador_display #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) dut (
        .reloj      (reloj),
        .reset_n    (reset_n),
        .cargar     (cargar),
        .dato       (dato),
        .ceros_izq  (ceros_izq),
        .Entrada    (Entrada),
        .habilita   (habilita),
        .digito     (digito),
        .ocupado    (ocupado),
        .fin_cuadro (fin_cuadro)
    );

    always #5 reloj = ~reloj;

    task automatic modelo_reset();
        m_k = 0; m_vis = '0; m_pend = '0;
        m_cz = 1'b0; m_pcz = 1'b0; m_ocup = 1'b0; m_fin = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic paso(input logic c, input logic [15:0] d, input logic z);
        logic bnd;
        cargar = c; dato = d; ceros_izq = z;
        @(posedge reloj);
        bnd = ((m_k % CUADRO) == CUADRO - 1);
        if (bnd && m_ocup) begin
            m_vis = m_pend;
            m_cz  = m_pcz;
        end
        m_ocup = c ? 1'b1 : (bnd ? 1'b0 : m_ocup);
        if (c) begin
            m_pend = d;
            m_pcz  = z;
        end
        m_fin = bnd;
        m_k++;
        #1;
        cargar = 1'b0;
    endtask

    function automatic logic [11:0] esperado();
        int          c, d;
        logic [3:0]  nib, hab;
        logic        blanco;
        c      = m_k % DIV;
        d      = (m_k / DIV) % 4;
        nib    = 4'((m_vis >> (4 * d)) & 16'hF);
        blanco = m_cz && (d != 0) && ((m_vis >> (4 * d)) == 16'h0);
        hab    = (c < GUARD || blanco) ? 4'hF : ~(4'b0001 << d);
        return {nib, hab, 2'(d), m_ocup, m_fin};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge reloj);
        #1;
        checks++;
        if (w_obs !== {4'h0, 4'hF, 2'd0, 1'b0, 1'b0}) begin
            errores++;
            $display("FAIL reset obtenido=%h esperado=%h", w_obs, {4'h0, 4'hF, 2'd0, 1'b0, 1'b0});
        end
        @(negedge reloj);
        reset_n = 1'b1;
        modelo_reset();
    endtask

    task automatic test_carga_1234();
        logic [3:0] ent_tab [4];
        logic [3:0] hab_tab [4];
        ent_tab = '{4'h4, 4'h3, 4'h2, 4'h1};
        hab_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        paso(1'b1, 16'h1234, 1'b0);
        checks++;
        if (ocupado !== 1'b1) begin
            errores++;
            $display("FAIL carga_ocupado obtenido=%b esperado=1", ocupado);
        end
        while (m_k < 2 * CUADRO) begin
            paso(1'b0, 16'h0, 1'b0);
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL carga_1234 k=%0d obtenido=%h esperado=%h", m_k, w_obs, esperado());
            end
            if (m_k >= CUADRO && (m_k % DIV) == GUARD) begin
                checks++;
                if ({Entrada, habilita} !== {ent_tab[(m_k / DIV) % 4], hab_tab[(m_k / DIV) % 4]}) begin
                    errores++;
                    $display("FAIL secuencia_1234 k=%0d obtenido=%h esperado=%h", m_k,
                             {Entrada, habilita}, {ent_tab[(m_k / DIV) % 4], hab_tab[(m_k / DIV) % 4]});
                end
            end
        end
    endtask

    task automatic test_blanco(input logic [15:0] v, input string nombre);
        paso(1'b1, v, 1'b1);
        repeat (2 * CUADRO) begin
            paso(1'b0, 16'h0, 1'b0);
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL %s k=%0d obtenido=%h esperado=%h", nombre, m_k, w_obs, esperado());
            end
        end
    endtask

    task automatic test_doble_carga();
        int pulsos;
        paso(1'b1, 16'hAAAA, 1'b0);
        repeat (5) paso(1'b0, 16'h0, 1'b0);
        paso(1'b1, 16'hBBBB, 1'b0);
        pulsos = 0;
        repeat (2 * CUADRO) begin
            paso(1'b0, 16'h0, 1'b0);
            if (fin_cuadro) pulsos++;
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL doble_carga k=%0d obtenido=%h esperado=%h", m_k, w_obs, esperado());
            end
        end
        checks++;
        if (pulsos !== 2) begin
            errores++;
            $display("FAIL fin_cuadro_periodo obtenido=%0d esperado=2", pulsos);
        end
        checks++;
        if (dut.r_vis.valor !== 16'hBBBB && Entrada !== 4'hB) begin
            errores++;
            $display("FAIL doble_carga_valor obtenido=%h esperado=b", Entrada);
        end
    endtask

    task automatic test_frontera();
        while ((m_k % CUADRO) != 10) paso(1'b0, 16'h0, 1'b0);
        paso(1'b1, 16'h1111, 1'b0);
        while ((m_k % CUADRO) != CUADRO - 1) paso(1'b0, 16'h0, 1'b0);
        paso(1'b1, 16'h5555, 1'b0);
        checks++;
        if ({ocupado, fin_cuadro} !== 2'b11) begin
            errores++;
            $display("FAIL frontera_ocupado obtenido=%b esperado=11", {ocupado, fin_cuadro});
        end
        repeat (2 * CUADRO) begin
            paso(1'b0, 16'h0, 1'b0);
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL frontera k=%0d obtenido=%h esperado=%h", m_k, w_obs, esperado());
            end
        end
    endtask

    task automatic test_aleatorio();
        logic c;
        repeat (3 * CUADRO) begin
            c = ($urandom_range(0, 11) == 0);
            paso(c, 16'($urandom), 1'($urandom));
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL aleatorio k=%0d obtenido=%h esperado=%h", m_k, w_obs, esperado());
            end
        end
    endtask

    task automatic test_reset_medio();
        while ((m_k % CUADRO) != 2 * DIV + 2) paso(1'b0, 16'h0, 1'b0);
        paso(1'b1, 16'hC3A9, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== {4'h0, 4'hF, 2'd0, 1'b0, 1'b0}) begin
            errores++;
            $display("FAIL reset_medio obtenido=%h esperado=%h", w_obs, {4'h0, 4'hF, 2'd0, 1'b0, 1'b0});
        end
        @(negedge reloj);
        reset_n = 1'b1;
        modelo_reset();
        repeat (CUADRO + DIV) begin
            paso(1'b0, 16'h0, 1'b0);
            checks++;
            if (w_obs !== esperado()) begin
                errores++;
                $display("FAIL tras_reset k=%0d obtenido=%h esperado=%h", m_k, w_obs, esperado());
            end
            if (m_k == GUARD) begin
                checks++;
                if ({Entrada, habilita} !== {4'h0, 4'b1110}) begin
                    errores++;
                    $display("FAIL tras_reset_d0 obtenido=%h esperado=0e", {Entrada, habilita});
                end
            end
        end
    endtask

    initial begin
        modelo_reset();
        test_reset();
        test_carga_1234();
        test_blanco(16'h0070, "blanco_0070");
        test_blanco(16'h0000, "blanco_0000");
        test_doble_carga();
        test_frontera();
        test_aleatorio();
        test_reset_medio();
        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
# controlador_display

Scan controller for the 4-digit multiplexed 7-segment display. Holds a 16-bit value (four hex nibbles) and presents one nibble at a time to the `Decodificador` input. It rotates the active-low digit enables at a programmable refresh rate, with guard time against ghosting and optional leading-zero blanking. New values are accepted through a load/busy handshake and committed only at frame boundaries, so a value is never shown torn across digits.

## Interface
- `DIV`, 50000: clock cycles per digit slot; legal range ≥ GUARD+1 and ≥ 2.
- `GUARD`, 4: cycles at the start of each slot with all enables off; legal range 0..DIV-1.
- `reloj` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cargar` input 1: one-cycle load strobe; samples `dato` and `ceros_izq`.
- `dato` input 16: value to display; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- `ceros_izq` input 1: 1 blanks leading zero digits.
- `Entrada` output 4: nibble to the decoder, registered.
- `habilita` output 4: digit enables, active-low, at most one bit low.
- `digito` output 2: index of the current slot.
- `ocupado` output 1: pending value not yet committed.
- `fin_cuadro` output 1: one-cycle pulse at the end of each frame (digit 3 slot).

## Operation
- Registers:
  - `cnt`: slot counter, 0..DIV-1, width clog2(DIV).
  - `dig`: 2-bit digit index.
  - `pend`, `pend_cz`: pending value and blanking flag.
  - `vis`, `vis_cz`: visible value and blanking flag.
  - `ocupado`.
- Slot counter: `cnt` increments every cycle. At `cnt==DIV-1` it wraps to 0 and `dig` increments, wrapping 3→0.
- Frame boundary: the edge where `cnt==DIV-1` and `dig==3`. On that edge:
  - `fin_cuadro` pulses.
  - If `ocupado`=1, `vis`/`vis_cz` take the pre-edge `pend`/`pend_cz` and `ocupado` clears.
- Load:
  - `cargar`=1 writes `pend`/`pend_cz` and sets `ocupado`.
  - When `cargar` and the frame boundary coincide, the commit uses the old `pend`. The new value becomes pending and `ocupado` stays 1.
  - A second `cargar` while `ocupado`=1 overwrites `pend`; last write wins.
- Outputs per slot, all registered from next-state values:
  - `Entrada` = `vis` nibble [4·dig+3 : 4·dig].
  - `digito` = dig.
  - `habilita` = 4'b1111 while `cnt<GUARD`; otherwise ~(4'b0001<<dig), unless the digit is blanked.
- Blanking: digit d is blanked when all of the following hold:
  - `vis_cz`=1
  - d≠0
  - nibble d and every higher nibble of `vis` are 0
- A blanked digit keeps `habilita`=4'b1111 for its whole slot. `Entrada` still shows the nibble.
- Reset (asynchronous, any time, including mid-slot or while pending):
  - `cnt`=0, `dig`=0
  - `vis`=0, `pend`=0, `vis_cz`=0, `pend_cz`=0
  - `Entrada`=0, `habilita`=4'b1111, `digito`=0, `ocupado`=0, `fin_cuadro`=0
  - A pending load is discarded.
- First slot after reset release: `cnt` counts from 0; digit 0 shows 0 once `cnt` reaches GUARD.

## Timing
- One frame = 4·DIV cycles. Each slot = GUARD off cycles + (DIV-GUARD) on cycles.
- `Entrada` and `digito` change on the same edge that starts a slot (cnt→0). `habilita` turns off no later than that edge.
- `cargar` to `ocupado`=1: one cycle.
- `cargar` to visible commit: at most 4·DIV cycles. The first slot showing the new value is digit 0 of the next frame.
- `fin_cuadro` is high exactly during the cycle after the boundary edge, concurrent with `digito`=0 and `cnt`=0.
- `ocupado` falls on the same edge `fin_cuadro` rises, unless a simultaneous `cargar` occurs.
- GUARD=0: no off time; enables switch directly digit to digit.

## Structure
- Shared package `display_pkg`:
  - N_DIGITOS=4
  - HAB_APAGADO=4'b1111
  - nibble and index widths
  - the scan-order function.
- Sub-module `divisor_barrido`:
  - Parameter DIV.
  - Ports `reloj`, `reset_n` → `cnt`, `fin_slot` (cnt==DIV-1).
- The controller FSM is the 4-state digit rotation (D0→D1→D2→D3→D0), advanced by `fin_slot`. Load/commit logic is in the top module.
- Downstream, `Entrada` connects directly to `Decodificador.Entrada`.

## Test plan
Bench parameters: DIV=8, GUARD=2.
- Reset then `cargar` `dato`=16'h1234, `ceros_izq`=0:
  - `ocupado`=1 until the first boundary.
  - Next frame: `Entrada` sequence 4,3,2,1 with `habilita` 1110,1101,1011,0111, each low for 6 cycles after 2 all-off cycles.
- `dato`=16'h0070, `ceros_izq`=1:
  - Digits 3 and 2 stay 1111 all slot.
  - Digit 1 shows 7; digit 0 shows 0 and is enabled.
- `dato`=16'h0000, `ceros_izq`=1: only digit 0 enabled, showing 0.
- Two `cargar` in one frame (16'hAAAA then 16'hBBBB): next frame shows B on all digits. `fin_cuadro` pulses every 32 cycles.
- `cargar` 16'h5555 on the exact boundary cycle, with pending 16'h1111:
  - Next frame shows 1111.
  - `ocupado` stays 1; the following frame shows 5555.
- Assert `reset_n`=0 mid-slot of digit 2 with a load pending:
  - Immediately `habilita`=1111, `Entrada`=0, `ocupado`=0.
  - After release: digit 0 shows 0.
